// File: rtl/mskaes_128bits_round_ctrl_if.sv
// Input/output handshake bundle of the masked AES-128 round controller.
interface mskaes_128bits_round_ctrl_if #(
  parameter int unsigned d = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [128*d-1:0] sh_plaintext;
  logic [128*d-1:0] sh_key;
  logic             out_valid;
  logic             out_ready;
  logic [128*d-1:0] sh_ciphertext;

  // Producer/consumer side
  modport master (
    output in_valid, sh_plaintext, sh_key, out_ready,
    input  in_ready, out_valid, sh_ciphertext
  );

  // Controller side
  modport slave (
    input  in_valid, sh_plaintext, sh_key, out_ready,
    output in_ready, out_valid, sh_ciphertext
  );
endinterface

// File: rtl/mskaes_128bits_round_ctrl.sv
// Round iteration controller for a masked AES-128 datapath instantiated by the parent.
// Holds the shared state/key, feeds the datapath for 10 rounds and emits the shared ciphertext.
module mskaes_128bits_round_ctrl #(
  parameter int unsigned d       = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mskaes_128bits_round_ctrl_if.slave bus,
  output logic                 busy,
  output logic                 rnd_req,
  output logic [128*d-1:0]     rd_state_in,
  output logic [128*d-1:0]     rd_key_in,
  output logic [8*d-1:0]       rd_rcon,
  input  logic [128*d-1:0]     rd_state_out,
  input  logic [128*d-1:0]     rd_key_out,
  input  logic [128*d-1:0]     rd_state_SR_out,
  input  logic [128*d-1:0]     rd_state_AK_out
);

  localparam int unsigned CntW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LATENCY);

  typedef enum logic [1:0] {StIdle, StRun, StOut} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [128*d-1:0] state_q, state_d;
  logic [128*d-1:0] key_q, key_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             round_done;
  logic             out_valid;

  assign round_done = (fsm_q == StRun) && (cnt_q == CntMax);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (bus.in_valid) fsm_d = StRun;
      StRun:   if (round_done && (rnd_q == 4'd10)) fsm_d = StOut;
      StOut:   if (bus.out_ready) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // Data/counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end

  // Data/counter next-state: load on accept, recapture datapath outputs at end of each round
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    if (fsm_q == StIdle) begin
      if (bus.in_valid) begin
        state_d = bus.sh_plaintext;
        key_d   = bus.sh_key;
        rnd_d   = 4'd1;
        cnt_d   = '0;
        rcon_d  = 8'h01;
      end
    end else if (fsm_q == StRun) begin
      if (round_done) begin
        key_d   = rd_key_out;
        // Last round skips MixColumns
        state_d = (rnd_q < 4'd10) ? rd_state_out : rd_state_SR_out;
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        cnt_d   = '0;
        rnd_d   = rnd_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // FSM outputs and datapath feeds
  always_comb begin
    out_valid         = (fsm_q == StOut);
    bus.in_ready      = (fsm_q == StIdle);
    bus.out_valid     = out_valid;
    busy              = (fsm_q == StRun) || (fsm_q == StOut);
    rnd_req           = (fsm_q == StRun);
    // Share-wise gating only, never combining shares
    bus.sh_ciphertext = rd_state_AK_out & {(128*d){out_valid}};
    rd_state_in       = state_q;
    rd_key_in         = key_q;
    // RCON travels in share 0; the remaining shares are zero
    rd_rcon           = '0;
    for (int i = 0; i < 8; i++) begin
      rd_rcon[d*i] = rcon_q[i];
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Bench for mskaes_128bits_round_ctrl: behavioural masked round datapath plus AES-128 reference.
module tb_mskaes_128bits_round_ctrl;
  localparam int unsigned D       = 2;
  localparam int unsigned LAT     = 4;
  localparam int unsigned W       = 128 * D;
  localparam int          RUN_CYC = 10 * (LAT + 1);

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic           busy, rnd_req;
  logic [W-1:0]   rd_state_in, rd_key_in, rd_state_out, rd_key_out;
  logic [W-1:0]   rd_state_SR_out, rd_state_AK_out;
  logic [8*D-1:0] rd_rcon;

  mskaes_128bits_round_ctrl_if #(.d(D)) bus ();

  mskaes_128bits_round_ctrl #(.d(D), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy           (busy),
    .rnd_req        (rnd_req),
    .rd_state_in    (rd_state_in),
    .rd_key_in      (rd_key_in),
    .rd_rcon        (rd_rcon),
    .rd_state_out   (rd_state_out),
    .rd_key_out     (rd_key_out),
    .rd_state_SR_out(rd_state_SR_out),
    .rd_state_AK_out(rd_state_AK_out)
  );

  logic [7:0] sbox_t [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- GF(2^8) / AES helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_t[v[127-8*k -: 8]];
    return r;
  endfunction

  // Byte k = row + 4*col, byte 0 in the MSBs
  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[127-8*(row+4*c) -: 8] = v[127-8*(row+4*((c+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-8*(4*c) -: 8];   a1 = v[127-8*(4*c+1) -: 8];
      a2 = v[127-8*(4*c+2) -: 8]; a3 = v[127-8*(4*c+3) -: 8];
      r[127-8*(4*c) -: 8]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
      r[127-8*(4*c+3) -: 8] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
    end
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    tmp = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]};
    tmp = tmp ^ {rc, 24'h0};
    w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    logic [7:0] rc;
    s = pt ^ key; k = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < 10) s = mix_columns(s);
      k = next_key(k, rc);
      s = s ^ k;
      rc = gmul(rc, 2);
    end
    return s;
  endfunction

  // ---------------- sharing helpers ----------------
  function automatic logic [127:0] unshare(input logic [W-1:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < D; j++) r[i] = r[i] ^ s[D*i+j];
    return r;
  endfunction

  function automatic logic [7:0] unshare8(input logic [8*D-1:0] s);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < D; j++) r[i] = r[i] ^ s[D*i+j];
    return r;
  endfunction

  function automatic logic [8*D-1:0] spread8(input logic [7:0] v);
    logic [8*D-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[D*i] = v[i];
    return r;
  endfunction

  function automatic logic [W-1:0] mkshare(input logic [127:0] v);
    logic [127:0] m, acc;
    logic [W-1:0] r;
    r = '0; acc = v;
    for (int j = 1; j < D; j++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      acc = acc ^ m;
      for (int i = 0; i < 128; i++) r[D*i+j] = m[i];
    end
    for (int i = 0; i < 128; i++) r[D*i] = acc[i];
    return r;
  endfunction

  // ---------------- behavioural round datapath (LAT stages, fresh remasking) ----------------
  logic [W-1:0] dp_state [LAT];
  logic [W-1:0] dp_sr    [LAT];
  logic [W-1:0] dp_key   [LAT];

  always @(posedge clk) begin
    dp_state[0] <= mkshare(mix_columns(shift_rows(sub_bytes(unshare(rd_state_in)
                                                            ^ unshare(rd_key_in)))));
    dp_sr[0]    <= mkshare(shift_rows(sub_bytes(unshare(rd_state_in) ^ unshare(rd_key_in))));
    dp_key[0]   <= mkshare(next_key(unshare(rd_key_in), unshare8(rd_rcon)));
    for (int i = 1; i < LAT; i++) begin
      dp_state[i] <= dp_state[i-1];
      dp_sr[i]    <= dp_sr[i-1];
      dp_key[i]   <= dp_key[i-1];
    end
  end

  assign rd_state_out    = dp_state[LAT-1];
  assign rd_state_SR_out = dp_sr[LAT-1];
  assign rd_key_out      = dp_key[LAT-1];
  assign rd_state_AK_out = rd_state_in ^ rd_key_in;

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
  end

  // ---------------- stimulus tasks ----------------
  // Called just after the accepting edge; returns cycles until out_valid and rnd_req count.
  task automatic wait_out(input bit chk_rcon, output int t, output int nreq);
    nreq = 0;
    t = 0;
    while (t < 4 * RUN_CYC) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (rnd_req) nreq++;
      if (t == 0) begin
        check("run_in_ready", bus.in_ready, 0);
        check("run_busy", busy, 1);
      end
      if (chk_rcon && t < RUN_CYC)
        check("rcon", rd_rcon, spread8(rcon_tab[t / (LAT + 1)]));
      t++;
    end
    check("latency", t, RUN_CYC);
    check("rnd_req_cycles", nreq, RUN_CYC);
    check("out_rnd_req", rnd_req, 0);
  endtask

  task automatic do_block(input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp_ct, input int hold, input bit chk_rcon);
    int t, nreq;
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.sh_plaintext = mkshare(pt);
    bus.sh_key       = mkshare(key);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.sh_plaintext = mkshare(~pt);
    wait_out(chk_rcon, t, nreq);
    check("ct", unshare(bus.sh_ciphertext), exp_ct);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_ct", unshare(bus.sh_ciphertext), exp_ct);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("ret_in_ready", bus.in_ready, 1);
    check("ret_out_valid", bus.out_valid, 0);
    check("ret_ct_zero", bus.sh_ciphertext, '0);
  endtask

  task automatic do_b2b(input logic [127:0] pa, input logic [127:0] ka,
                        input logic [127:0] pb, input logic [127:0] kb);
    int t, nreq;
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    bus.sh_plaintext = mkshare(pa);
    bus.sh_key       = mkshare(ka);
    @(negedge clk);
    check("b2b_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    // Still valid during RUN; must be ignored until the controller is idle again
    bus.sh_plaintext = mkshare(pb);
    bus.sh_key       = mkshare(kb);
    wait_out(1'b0, t, nreq);
    check("b2b_ct_a", unshare(bus.sh_ciphertext), ref_aes(pa, ka));
    @(negedge clk);
    check("b2b_gap_in_ready", bus.in_ready, 1);
    check("b2b_gap_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(1'b0, t, nreq);
    check("b2b_ct_b", unshare(bus.sh_ciphertext), ref_aes(pb, kb));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("b2b_end_in_ready", bus.in_ready, 1);
  endtask

  task automatic do_reset_mid(input logic [127:0] pt, input logic [127:0] key);
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.sh_plaintext = mkshare(pt);
    bus.sh_key       = mkshare(key);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Round 5, cnt 2
    for (int t = 0; t <= 4 * (LAT + 1) + 2; t++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rnd_req", rnd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_state", rd_state_in, '0);
    check("rst_key", rd_key_in, '0);
    check("rst_rcon", rd_rcon, '0);
    check("rst_ct", bus.sh_ciphertext, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", bus.in_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] p, k, p2, k2;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.sh_plaintext = '0;
    bus.sh_key       = '0;
    #1 rst_n = 1'b0;
    #3;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rnd_req", rnd_req, 0);
    check("reset_ct", bus.sh_ciphertext, '0);
    check("reset_state", rd_state_in, '0);
    check("reset_key", rd_key_in, '0);
    check("reset_rcon", rd_rcon, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vector with RCON trace
    do_block(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b1);

    // Backpressure with random data
    p = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    do_block(p, k, ref_aes(p, k), 20, 1'b1);

    // Back-to-back
    p  = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_b2b(p, k, p2, k2);

    // Abort mid-run, then a clean encryption
    do_reset_mid(p, k);
    do_block(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0);

    // Random blocks
    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      do_block(p, k, ref_aes(p, k), int'($urandom_range(0, 3)), 1'b0);
    end

    // Many sharings of the same vector
    for (int i = 0; i < 100; i++) do_block(FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
